// File: rtl/cpu_boot_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_boot_sequencer_if
// Description : Host/CPU-side signal bundle of the boot sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_boot_sequencer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic [ADDR_WIDTH:0]   load_len;
  logic [1:0]            init_mode;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic                  rf_we;
  logic [4:0]            rf_addr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  cpu_run;
  logic                  halt;
  logic                  busy;
  logic                  done;
  logic                  halted;
  logic                  len_err;
  logic [CNT_WIDTH-1:0]  cycle_cnt;
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    output start, load_len, init_mode, in_valid, in_data, halt,
    input  in_ready, imem_we, imem_addr, imem_wdata, rf_we, rf_addr, rf_wdata,
           cpu_run, busy, done, halted, len_err, cycle_cnt, checksum
  );

  modport slave (
    input  start, load_len, init_mode, in_valid, in_data, halt,
    output in_ready, imem_we, imem_addr, imem_wdata, rf_we, rf_addr, rf_wdata,
           cpu_run, busy, done, halted, len_err, cycle_cnt, checksum
  );
endinterface
`default_nettype wire

// File: rtl/cpu_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_boot_sequencer
// Description : Loads a program image, initialises the register file and
//               runs the CPU for a bounded number of cycles.
//               Optional macro BOOT_CHECKSUM_EN adds a running input checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_boot_sequencer #(
  parameter int INSTR_MEM_SIZE = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int N_REGISTERS    = 32,
  parameter int RUN_CYCLES     = 6,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  cpu_boot_sequencer_if.slave  bus
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_load    = 3'd1;
  localparam logic [2:0] c_st_reginit = 3'd2;
  localparam logic [2:0] c_st_run     = 3'd3;
  localparam logic [2:0] c_st_done    = 3'd4;

  localparam logic [ADDR_WIDTH:0]  c_mem_size   = (ADDR_WIDTH+1)'(INSTR_MEM_SIZE);
  localparam logic [4:0]           c_last_reg   = 5'(N_REGISTERS-1);
  localparam logic [CNT_WIDTH-1:0] c_run_cycles = CNT_WIDTH'(RUN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max    = '1;
  localparam logic [1:0]           c_mode_skip  = 2'd3;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_widx;
  logic [1:0]            r_mode;
  logic [4:0]            r_ridx;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [DATA_WIDTH-1:0] r_imem_wdata;
  logic                  r_halted;
  logic                  r_len_err;
  logic [CNT_WIDTH-1:0]  r_cycle_cnt;

  logic                  w_in_ready;
  logic                  w_handshake;
  logic                  w_start_ok;
  logic                  w_len_over;
  logic [ADDR_WIDTH:0]   w_eff_len;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_rf_we;
  logic [DATA_WIDTH-1:0] w_rf_wdata;

  assign w_in_ready  = (r_state == c_st_load);
  assign w_handshake = bus.in_valid && w_in_ready;
  assign w_start_ok  = bus.start && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_len_over  = (bus.load_len > c_mem_size);
  assign w_eff_len   = w_len_over ? c_mem_size : bus.load_len;
  assign w_cnt_inc   = (r_cycle_cnt == c_cnt_max) ? r_cycle_cnt : r_cycle_cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= c_st_idle;
      r_len        <= '0;
      r_widx       <= '0;
      r_mode       <= 2'd0;
      r_ridx       <= 5'd0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_halted     <= 1'b0;
      r_len_err    <= 1'b0;
      r_cycle_cnt  <= '0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        c_st_idle, c_st_done: begin
          if (w_start_ok) begin
            r_len       <= w_eff_len;
            r_mode      <= bus.init_mode;
            r_len_err   <= w_len_over;
            r_halted    <= 1'b0;
            r_cycle_cnt <= '0;
            r_widx      <= '0;
            r_ridx      <= 5'd0;
            r_state     <= (w_eff_len == '0) ? c_st_reginit : c_st_load;
          end
        end
        c_st_load: begin
          if (w_handshake) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_widx[ADDR_WIDTH-1:0];
            r_imem_wdata <= bus.in_data;
            r_widx       <= r_widx + 1'b1;
            if (r_widx + 1'b1 == r_len) begin
              r_state <= c_st_reginit;
            end
          end
        end
        c_st_reginit: begin
          if ((r_mode == c_mode_skip) || (r_ridx == c_last_reg)) begin
            r_ridx  <= 5'd0;
            r_state <= c_st_run;
          end else begin
            r_ridx <= r_ridx + 5'd1;
          end
        end
        c_st_run: begin
          r_cycle_cnt <= w_cnt_inc;
          // halt takes priority when it coincides with budget expiry
          if (bus.halt) begin
            r_halted <= 1'b1;
            r_state  <= c_st_done;
          end else if (w_cnt_inc >= c_run_cycles) begin
            r_state <= c_st_done;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign w_rf_we = (r_state == c_st_reginit) && (r_mode != c_mode_skip);

  always_comb begin
    w_rf_wdata = '0;
    if (w_rf_we) begin
      case (r_mode)
        2'd1:    w_rf_wdata = DATA_WIDTH'(r_ridx);
        2'd2:    w_rf_wdata = '1;
        default: w_rf_wdata = '0;
      endcase
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_handshake) begin
      r_checksum <= r_checksum + bus.in_data;
    end
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = '0;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign bus.rf_we      = w_rf_we;
  assign bus.rf_addr    = w_rf_we ? r_ridx : 5'd0;
  assign bus.rf_wdata   = w_rf_wdata;
  assign bus.cpu_run    = (r_state == c_st_run);
  assign bus.busy       = (r_state == c_st_load) || (r_state == c_st_reginit) ||
                          (r_state == c_st_run);
  assign bus.done       = (r_state == c_st_done);
  assign bus.halted     = r_halted;
  assign bus.len_err    = r_len_err;
  assign bus.cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_boot_sequencer
// Description : Scoreboard bench for cpu_boot_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_boot_sequencer;

  localparam int MEMSZ = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREG  = 32;
  localparam int RUNC  = 6;
  localparam int CW    = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cpu_boot_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  cpu_boot_sequencer #(
    .INSTR_MEM_SIZE (MEMSZ),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .N_REGISTERS    (NREG),
    .RUN_CYCLES     (RUNC),
    .CNT_WIDTH      (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW+DW-1:0] q_imem[$];
  logic [5+DW-1:0]  q_rf[$];
  logic [AW+DW-1:0] e_im;
  logic [5+DW-1:0]  e_rf;

  always @(negedge clock) begin
    if (bus.imem_we) begin
      if (q_imem.size() == 0) begin
        check_val("imem_extra_write", 64'(q_imem.size()), 64'd1);
      end else begin
        e_im = q_imem.pop_front();
        check_val("imem_addr", 64'(bus.imem_addr), 64'(e_im[AW+DW-1:DW]));
        check_val("imem_wdata", 64'(bus.imem_wdata), 64'(e_im[DW-1:0]));
      end
    end
    if (bus.rf_we) begin
      if (q_rf.size() == 0) begin
        check_val("rf_extra_write", 64'(q_rf.size()), 64'd1);
      end else begin
        e_rf = q_rf.pop_front();
        check_val("rf_addr", 64'(bus.rf_addr), 64'(e_rf[5+DW-1:DW]));
        check_val("rf_wdata", 64'(bus.rf_wdata), 64'(e_rf[DW-1:0]));
      end
    end
  end

  logic [DW-1:0] prog [3];
  int            exp_len;
  bit            exp_len_err;
  logic [DW-1:0] exp_sum;
  int            accepted;
  int            load_cycles;

  function automatic logic [DW-1:0] rf_pat(input logic [1:0] mode, input int idx);
    case (mode)
      2'd1:    return DW'(idx);
      2'd2:    return '1;
      default: return '0;
    endcase
  endfunction

  task automatic start_boot(input int len, input logic [1:0] mode);
    @(posedge clock); #1;
    bus.start     = 1'b1;
    bus.load_len  = (AW+1)'(len);
    bus.init_mode = mode;
    exp_len_err   = (len > MEMSZ);
    exp_len       = exp_len_err ? MEMSZ : len;
    exp_sum       = '0;
    accepted      = 0;
    load_cycles   = 0;
    if (mode != 2'd3) begin
      for (int i = 0; i < NREG; i++) q_rf.push_back({5'(i), rf_pat(mode, i)});
    end
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic load_words(input bit toggle);
    int guard = 0;
    while (bus.in_ready && guard < 200) begin
      bus.in_valid = toggle ? ((load_cycles % 2) == 0) : 1'b1;
      bus.in_data  = (accepted < 3) ? prog[accepted] : DW'($urandom);
      if (bus.in_valid) begin
        q_imem.push_back({AW'(accepted), bus.in_data});
        exp_sum += bus.in_data;
        accepted++;
      end
      load_cycles++;
      guard++;
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    check_val("words_accepted", 64'(accepted), 64'(exp_len));
  endtask

  task automatic finish_run(input int halt_at, input bit poke_start);
    int  run   = 0;
    int  guard = 0;
    bit  seen  = 1'b0;
    bit  exp_halted;
    int  exp_cnt;
    logic [DW-1:0] exp_ck;
    while (!seen && guard < 300) begin
      bus.start = 1'b0;
      bus.halt  = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.cpu_run) begin
          run++;
          bus.halt = (run == halt_at);
          if (poke_start && run == 2) bus.start = 1'b1;
        end
        @(posedge clock); #1;
        guard++;
      end
    end
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    exp_halted = (halt_at >= 1) && (halt_at <= RUNC);
    exp_cnt    = exp_halted ? halt_at : RUNC;
`ifdef BOOT_CHECKSUM_EN
    exp_ck = exp_sum;
`else
    exp_ck = '0;
`endif
    check_val("done_reached", 64'(seen), 64'd1);
    check_val("halted", 64'(bus.halted), 64'(exp_halted));
    check_val("cycle_cnt", 64'(bus.cycle_cnt), 64'(exp_cnt));
    check_val("run_cycles_seen", 64'(run), 64'(exp_cnt));
    check_val("len_err", 64'(bus.len_err), 64'(exp_len_err));
    check_val("busy_in_done", 64'(bus.busy), 64'd0);
    check_val("cpu_run_in_done", 64'(bus.cpu_run), 64'd0);
    check_val("checksum", 64'(bus.checksum), 64'(exp_ck));
    check_val("imem_q_drained", 64'(q_imem.size()), 64'd0);
    check_val("rf_q_drained", 64'(q_rf.size()), 64'd0);
    @(posedge clock); #1;
    check_val("done_hold", 64'(bus.done), 64'd1);
    check_val("cnt_hold", 64'(bus.cycle_cnt), 64'(exp_cnt));
  endtask

  initial begin
    int guard;
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0003;
    prog[2] = 32'h0109_5020;
    bus.start = 1'b0; bus.load_len = '0; bus.init_mode = 2'd0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.halt = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_val("rst_imem_we", 64'(bus.imem_we), 64'd0);
    check_val("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
    check_val("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
    check_val("rst_rf_we", 64'(bus.rf_we), 64'd0);
    check_val("rst_rf_addr", 64'(bus.rf_addr), 64'd0);
    check_val("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    check_val("rst_cpu_run", 64'(bus.cpu_run), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_halted", 64'(bus.halted), 64'd0);
    check_val("rst_len_err", 64'(bus.len_err), 64'd0);
    check_val("rst_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
    check_val("rst_checksum", 64'(bus.checksum), 64'd0);
    reset = 1'b0;

    // Basic boot: 3 words back-to-back, index pattern, budget expiry
    start_boot(3, 2'd1);
    check_val("done_cleared", 64'(bus.done), 64'd0);
    check_val("busy_in_load", 64'(bus.busy), 64'd1);
    load_words(1'b0);
    check_val("load_len_cycles", 64'(load_cycles), 64'd3);
    finish_run(0, 1'b0);

    // Gapped valid, zero pattern
    start_boot(3, 2'd0);
    load_words(1'b1);
    check_val("gapped_load_cycles", 64'(load_cycles), 64'd5);
    finish_run(0, 1'b0);

    // Oversized length saturates, all-ones pattern
    start_boot(40, 2'd2);
    load_words(1'b0);
    check_val("sat_in_ready_low", 64'(bus.in_ready), 64'd0);
    finish_run(0, 1'b0);

    // Halt in the 3rd RUN cycle, then halt coinciding with budget expiry
    start_boot(3, 2'd1);
    load_words(1'b0);
    finish_run(3, 1'b0);
    start_boot(2, 2'd3);
    load_words(1'b0);
    finish_run(RUNC, 1'b0);

    // Reset mid-REGINIT at rf_addr 10
    start_boot(3, 2'd1);
    load_words(1'b0);
    guard = 0;
    while (!(bus.rf_we && bus.rf_addr == 5'd10) && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    check_val("reach_rf_addr10", 64'(bus.rf_we && bus.rf_addr == 5'd10), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_val("abort_rf_we", 64'(bus.rf_we), 64'd0);
    check_val("abort_busy", 64'(bus.busy), 64'd0);
    check_val("abort_cpu_run", 64'(bus.cpu_run), 64'd0);
    check_val("abort_done", 64'(bus.done), 64'd0);
    check_val("abort_rf_left", 64'(q_rf.size()), 64'd21);
    q_rf.delete();
    reset = 1'b0;

    // Zero-length load with skipped init goes straight to RUN
    start_boot(0, 2'd3);
    check_val("skip_busy", 64'(bus.busy), 64'd1);
    check_val("skip_in_ready", 64'(bus.in_ready), 64'd0);
    check_val("skip_rf_we", 64'(bus.rf_we), 64'd0);
    check_val("skip_not_run_yet", 64'(bus.cpu_run), 64'd0);
    @(posedge clock); #1;
    check_val("skip_run", 64'(bus.cpu_run), 64'd1);
    finish_run(0, 1'b0);

    // start during RUN is ignored
    start_boot(3, 2'd2);
    load_words(1'b0);
    finish_run(0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
